exec_unit: RTL

Execute stage directly downstream of the instruction decoder in the JSilicon 8-bit core. Consumes the decoded `opcode[2:0]`/`operand[3:0]` pair and applies it to an 8-bit accumulator with carry/zero flags. Most ops complete in one cycle; the shift and multiply ops are iterative multi-cycle. A valid/ready handshake stalls the decoder while a multi-cycle op is in flight.

---
 rtl/exec_unit_if.sv | 22 ++
 rtl/exec_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/exec_unit_if.sv
// Decoder-to-execute handshake bundle: decoded instruction in, accumulator,
// flags, completion pulse and ready back out.
interface exec_unit_if;
    logic       in_valid;
    logic [2:0] opcode;
    logic [3:0] operand;
    logic       in_ready;
    logic [7:0] acc_out;
    logic       carry;
    logic       zero;
    logic       done;

    modport master (
        output in_valid, opcode, operand,
        input  in_ready, acc_out, carry, zero, done
    );

    modport slave (
        input  in_valid, opcode, operand,
        output in_ready, acc_out, carry, zero, done
    );
endinterface

// File: rtl/exec_unit.sv
// Execute stage of the JSilicon 8-bit core: accumulator ALU with iterative
// shift-left (SHLI) and 8x4 shift-add multiply (MULI) behind valid/ready.
module exec_unit (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ena,
    exec_unit_if.slave bus
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LDI  = 3'd1,
        OP_ADDI = 3'd2,
        OP_SUBI = 3'd3,
        OP_ANDI = 3'd4,
        OP_XORI = 3'd5,
        OP_SHLI = 3'd6,
        OP_MULI = 3'd7
    } opcode_e;

    state_e      state_q, state_d;
    logic        is_mul_q, is_mul_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [11:0] work_q, work_d;      // shift register (SHLI) or multiplicand (MULI)
    logic [3:0]  mplier_q, mplier_d;
    logic [11:0] prod_q, prod_d;
    logic [7:0]  acc_q, acc_d;
    logic        carry_q, carry_d;
    logic        zero_q, zero_d;
    logic        done_q, done_d;

    opcode_e     op;
    logic [7:0]  imm;
    logic [8:0]  sum9;
    logic [8:0]  diff9;
    logic [11:0] prod_step;

    assign op        = opcode_e'(bus.opcode);
    assign imm       = {4'b0000, bus.operand};
    assign sum9      = {1'b0, acc_q} + {1'b0, imm};
    assign diff9     = {1'b0, acc_q} - {1'b0, imm};
    assign prod_step = mplier_q[0] ? (prod_q + work_q) : prod_q;

    // NOTE: every _d is given its hold value first, so no path through this block can infer a latch.
    always_comb begin
        state_d  = state_q;
        is_mul_d = is_mul_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        done_d   = done_q;

        if (ena) begin
            done_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        done_d = 1'b1;
                        case (op)
                            OP_NOP: ;
                            OP_LDI: begin
                                acc_d   = imm;
                                carry_d = 1'b0;
                            end
                            OP_ADDI: {carry_d, acc_d} = sum9;
                            OP_SUBI: begin
                                acc_d   = diff9[7:0];
                                carry_d = diff9[8];
                            end
                            OP_ANDI: begin
                                acc_d   = acc_q & imm;
                                carry_d = 1'b0;
                            end
                            OP_XORI: begin
                                acc_d   = acc_q ^ imm;
                                carry_d = 1'b0;
                            end
                            OP_SHLI: begin
                                if (bus.operand[2:0] == 3'd0) begin
                                    carry_d = 1'b0;
                                end else begin
                                    done_d   = 1'b0;
                                    work_d   = {4'b0000, acc_q};
                                    cnt_d    = bus.operand[2:0];
                                    is_mul_d = 1'b0;
                                    state_d  = S_RUN;
                                end
                            end
                            OP_MULI: begin
                                done_d   = 1'b0;
                                work_d   = {4'b0000, acc_q};
                                mplier_d = bus.operand;
                                prod_d   = 12'h000;
                                cnt_d    = 3'd4;
                                is_mul_d = 1'b1;
                                state_d  = S_RUN;
                            end
                            default: ;
                        endcase
                    end
                end

                S_RUN: begin
                    cnt_d  = cnt_q - 3'd1;
                    work_d = {work_q[10:0], 1'b0};
                    if (is_mul_q) begin
                        prod_d   = prod_step;
                        mplier_d = {1'b0, mplier_q[3:1]};
                    end
                    // Last iteration: the architectural state sees only the final result.
                    if (cnt_q == 3'd1) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        if (is_mul_q) begin
                            acc_d   = prod_step[7:0];
                            carry_d = |prod_step[11:8];
                        end else begin
                            acc_d   = {work_q[6:0], 1'b0};
                            carry_d = work_q[7];
                        end
                    end
                end

                default: state_d = S_IDLE;
            endcase
            zero_d = (acc_d == 8'h00);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            is_mul_q <= 1'b0;
            cnt_q    <= 3'd0;
            work_q   <= 12'h000;
            mplier_q <= 4'h0;
            prod_q   <= 12'h000;
            acc_q    <= 8'h00;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_mul_q <= is_mul_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign bus.in_ready = (state_q == S_IDLE);
    assign bus.acc_out  = acc_q;
    assign bus.carry    = carry_q;
    assign bus.zero     = zero_q;
    assign bus.done     = done_q;

endmodule
